// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the 1101 detector.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_e;

  localparam logic [3:0] SEQ_SYNC_DEFAULT = 4'b1101;

  function automatic int seq_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Parallel-load shift register feeding the serial output MSB-first.
module seq_tx_shifter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_sr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= r_sr << 1;
    end
  end

  assign o_msb = r_sr[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Framed serial transmitter: sync word, latched payload, then idle gap.
//   state   | meaning
//   IDLE    | Ready=1, waiting for Start; Dout=0
//   SYNC    | shifting the sync word out MSB-first
//   DATA    | shifting the latched payload out MSB-first; Done on last bit
//   GAP     | GAP idle cycles with Dout=0 before returning to IDLE
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int                PAYLOAD_W = 8,
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC      = SEQ_SYNC_DEFAULT,
  parameter int                GAP       = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [PAYLOAD_W-1:0] Data,
  output logic                 Ready,
  output logic                 Dout,
  output logic                 Busy,
  output logic                 Done
);

  localparam int MAXC  = seq_max3(SYNC_W, PAYLOAD_W, GAP);
  localparam int CNT_W = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;
  logic             w_shift;
  logic             w_msb;
  logic [SYNC_W-1:0] w_sync_vec;
  logic             w_cnt_zero;

  seq_tx_shifter #(
    .W (PAYLOAD_W)
  ) u_shifter (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (Data),
    .o_msb   (w_msb)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SYNC;
          w_cnt_nxt   = SYNC_LAST;
        end
      end
      ST_SYNC: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = DATA_LAST;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_DATA: begin
        w_shift = 1'b1;
        if (w_cnt_zero) begin
          // A zero-length gap drops straight back to IDLE for one cycle.
          if (GAP > 0) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = GAP_LAST;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_sync_vec = SYNC >> r_cnt;

  always_comb begin
    Dout = 1'b0;
    unique case (r_state)
      ST_SYNC: Dout = w_sync_vec[0];
      ST_DATA: Dout = w_msb;
      default: Dout = 1'b0;
    endcase
  end

  assign Ready = (r_state == ST_IDLE);
  assign Busy  = (r_state != ST_IDLE);
  assign Done  = (r_state == ST_DATA) && w_cnt_zero;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: scoreboarded frames, ignored starts, resets, GAP=0 streaming.
module tb_seq_pattern_tx;

  typedef struct packed {
    logic dout;
    logic done;
    logic busy;
    logic ready;
  } exp_t;

  localparam logic [3:0] SYNC_REF = 4'b1101;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [7:0] data_a, data_b;
  logic       ready_a, dout_a, busy_a, done_a;
  logic       ready_b, dout_b, busy_b, done_b;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int det_state  = 0;
  int y_cnt      = 0;

  seq_pattern_tx dut_a (
    .Clock (clk),
    .Reset (rst),
    .Start (start_a),
    .Data  (data_a),
    .Ready (ready_a),
    .Dout  (dout_a),
    .Busy  (busy_a),
    .Done  (done_a)
  );

  seq_pattern_tx #(
    .GAP (0)
  ) dut_b (
    .Clock (clk),
    .Reset (rst),
    .Start (start_b),
    .Data  (data_b),
    .Ready (ready_b),
    .Dout  (dout_b),
    .Busy  (busy_b),
    .Done  (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 1101 Moore detector (overlapping), fed by dut_a's serial output.
  function automatic int det_next(input int s, input logic b);
    case (s)
      0:       return b ? 1 : 0;
      1:       return b ? 2 : 0;
      2:       return b ? 2 : 3;
      3:       return b ? 4 : 0;
      default: return b ? 2 : 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
    if (det_state == 4) y_cnt <= y_cnt + 1;
    if (rst) det_state <= 0;
    else     det_state <= det_next(det_state, dout_a);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input bit sel, input exp_t e);
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  task automatic push_frame(input bit sel, input logic [7:0] d, input int gap);
    exp_t e;
    logic [3:0] s;
    s = SYNC_REF;
    for (int i = 3; i >= 0; i--) begin
      e = '{dout: s[i], done: 1'b0, busy: 1'b1, ready: 1'b0};
      push(sel, e);
    end
    for (int i = 7; i >= 0; i--) begin
      e = '{dout: d[i], done: (i == 0), busy: 1'b1, ready: 1'b0};
      push(sel, e);
    end
    for (int i = 0; i < gap; i++) begin
      e = '{dout: 1'b0, done: 1'b0, busy: 1'b1, ready: 1'b0};
      push(sel, e);
    end
    e = '{dout: 1'b0, done: 1'b0, busy: 1'b0, ready: 1'b1};
    push(sel, e);
  endtask

  task automatic step_cmp(input bit sel);
    exp_t e;
    bit   empty;
    @(negedge clk);
    empty = sel ? (q_b.size() == 0) : (q_a.size() == 0);
    if (empty) begin
      n_checks++;
      n_err++;
      $error("FAIL scoreboard_empty: observed no entry expected an entry (sel=%0d)", sel);
    end else begin
      if (sel) e = q_b.pop_front();
      else     e = q_a.pop_front();
      if (sel) begin
        chk("b_dout",  dout_b,  e.dout);
        chk("b_done",  done_b,  e.done);
        chk("b_busy",  busy_b,  e.busy);
        chk("b_ready", ready_b, e.ready);
      end else begin
        chk("a_dout",  dout_a,  e.dout);
        chk("a_done",  done_a,  e.done);
        chk("a_busy",  busy_a,  e.busy);
        chk("a_ready", ready_a, e.ready);
      end
    end
  endtask

  initial begin
    int base_a, base_b, base_y;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready_a", ready_a, 1'b1);
    chk("rst_busy_a",  busy_a,  1'b0);
    chk("rst_dout_a",  dout_a,  1'b0);
    chk("rst_done_a",  done_a,  1'b0);
    chk("rst_ready_b", ready_b, 1'b1);
    chk("rst_busy_b",  busy_b,  1'b0);

    // Single A5 frame
    #1 base_a = done_cnt_a;
    data_a = 8'hA5; start_a = 1'b1;
    push_frame(1'b0, 8'hA5, 2);
    for (int c = 1; c <= 15; c++) begin
      step_cmp(1'b0);
      start_a = 1'b0;
    end
    #1 chk("a5_done_pulses", done_cnt_a - base_a, 1);

    // Start with new data while busy must be ignored
    data_a = 8'hA5; start_a = 1'b1;
    push_frame(1'b0, 8'hA5, 2);
    for (int c = 1; c <= 15; c++) begin
      step_cmp(1'b0);
      start_a = 1'b0;
      if (c == 5) begin
        start_a = 1'b1;
        data_a  = 8'hFF;
      end
    end

    // Reset and Start on the same edge: reset wins
    rst = 1'b1; start_a = 1'b1; data_a = 8'hA5;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    chk("rs_ready", ready_a, 1'b1);
    chk("rs_busy",  busy_a,  1'b0);
    chk("rs_dout",  dout_a,  1'b0);
    repeat (3) @(negedge clk);
    chk("rs_still_idle", busy_a, 1'b0);

    // Reset on cycle 6 aborts the frame with no Done
    #1 base_a = done_cnt_a;
    data_a = 8'hA5; start_a = 1'b1;
    push_frame(1'b0, 8'hA5, 2);
    for (int c = 1; c <= 6; c++) begin
      step_cmp(1'b0);
      start_a = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_a.delete();
    chk("abort_ready", ready_a, 1'b1);
    chk("abort_busy",  busy_a,  1'b0);
    chk("abort_dout",  dout_a,  1'b0);
    repeat (16) @(negedge clk);
    chk("abort_idle", busy_a, 1'b0);
    #1 chk("abort_no_done", done_cnt_a - base_a, 0);

    // Loopback into the 1101 detector: one hit per all-zero payload frame
    base_y = y_cnt;
    for (int f = 0; f < 2; f++) begin
      data_a = 8'h00; start_a = 1'b1;
      push_frame(1'b0, 8'h00, 2);
      for (int c = 1; c <= 15; c++) begin
        step_cmp(1'b0);
        start_a = 1'b0;
      end
    end
    #1 chk("det_y_pulses", y_cnt - base_y, 2);

    // GAP=0 instance with Start held: back-to-back frames, one IDLE cycle apart
    #1 base_b = done_cnt_b;
    data_b = 8'h0F; start_b = 1'b1;
    push_frame(1'b1, 8'h0F, 0);
    push_frame(1'b1, 8'hF0, 0);
    for (int c = 1; c <= 26; c++) begin
      step_cmp(1'b1);
      if (c == 1)  data_b  = 8'hF0;
      if (c == 14) start_b = 1'b0;
    end
    #1 chk("b2b_done_pulses", done_cnt_b - base_b, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter PAYLOAD_W, default 8: payload bits per frame, range 1..32.
REQ-002 Parameter SYNC_W, default 4: sync word width, range 1..8.
REQ-003 Parameter SYNC, default 4'b1101: sync word sent MSB-first ahead of each payload.
REQ-004 Parameter GAP, default 2: idle cycles with Dout=0 after each frame, range 0..15.
REQ-005 Port Clock  input  1: single clock; all state changes on the rising edge.
REQ-006 Port Reset  input  1: synchronous, active-high reset, sampled on the Clock rising edge.
REQ-007 Port Start  input  1: frame request; qualified by Ready.
REQ-008 Port Data  input  PAYLOAD_W: payload, captured on acceptance.
REQ-009 Port Ready  output  1: high only in IDLE; the block can accept Start.
REQ-010 Port Dout  output  1: registered serial bit stream.
REQ-011 Port Busy  output  1: high in SYNC, DATA and GAP.
REQ-012 Port Done  output  1: one-cycle pulse marking the last payload bit.

Function
REQ-013 Moore FSM with states IDLE, SYNC, DATA and GAP; Dout, Ready, Busy and Done SHALL decode only from registered state and counters.
REQ-014 Acceptance SHALL occur on an edge where Start=1 and Ready=1; Data SHALL be latched into the shift register on that edge.
REQ-015 Start SHALL be ignored while Ready=0, and the latched payload SHALL NOT change.
REQ-016 IDLE->SYNC on acceptance; Dout SHALL show SYNC[SYNC_W-1] in the first cycle after the accepting edge (latency 1).
REQ-017 SYNC SHALL drive SYNC_W bits MSB-first, one per cycle, then enter DATA.
REQ-018 DATA SHALL drive PAYLOAD_W latched bits MSB-first, one per cycle.
REQ-019 Done SHALL be 1 exactly during the cycle the last payload bit is on Dout.
REQ-020 After the last payload bit the FSM SHALL enter GAP when GAP>0, otherwise IDLE.
REQ-021 GAP SHALL last exactly GAP cycles with Dout=0, then enter IDLE.
REQ-022 Dout SHALL be 0 in IDLE and GAP.
REQ-023 Bit counters SHALL be sized with $clog2 of the largest count and SHALL NOT wrap mid-frame.
REQ-024 With GAP=0, a Start held high SHALL produce back-to-back frames with exactly one IDLE cycle between frames.
REQ-025 Total frame occupancy SHALL be SYNC_W+PAYLOAD_W+GAP cycles of Busy=1.

Reset
REQ-026 Reset=1 on an edge SHALL force IDLE, clear counters and shift register, and set Dout=0, Busy=0, Done=0, Ready=1 from the next cycle.
REQ-027 Reset SHALL have priority over Start on the same edge.
REQ-028 Reset mid-frame SHALL abort the frame; no Done pulse SHALL follow.

Structure
REQ-029 A shared package seq_pkg SHALL hold the state enum (IDLE, SYNC, DATA, GAP) and the default sync constant 4'b1101, shared with the 1101 detector.
REQ-030 One sub-module, seq_tx_shifter, SHALL hold the parallel-load, MSB-first shift register; the FSM and counters stay in seq_pattern_tx.

Verification
REQ-031 Defaults, Data=8'hA5, Start pulsed 1 cycle -> Dout=1,1,0,1,1,0,1,0,0,1,0,1 on cycles 1..12, Done on cycle 12, Dout=0 on cycles 13..14, Ready=1 from cycle 15.
REQ-032 Start pulsed while Busy=1 with Data=8'hFF -> ignored; the current frame completes unchanged.
REQ-033 Reset asserted on cycle 6 of an 8'hA5 frame -> next cycle Ready=1, Busy=0, Dout=0; no Done pulse.
REQ-034 GAP=0, Start held high, Data=8'h0F then 8'hF0 -> two frames with one IDLE cycle between them and two Done pulses.
REQ-035 Loopback into the team's 1101 Moore detector, Data=8'h00 -> detector Y pulses once per frame, on the sync word.
REQ-036 Reset and Start high on the same edge -> stays in IDLE with Ready=1; no frame starts.
